// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state encoding and line-level constants for serial_deframer.
// Revision: 1.0
`default_nettype none

package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd2
`ifdef SERIAL_DEFRAMER_PARITY_EN
    ,
    PARITY = 2'd3
`endif
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/serial_bit_counter.sv
// serial_bit_counter: loadable up-counter that saturates at TERMINAL and flags it.
// Revision: 1.0
`default_nettype none

module serial_bit_counter #(
  parameter int CNT_W    = 4,
  parameter int TERMINAL = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  assign tc = (count == CNT_W'(TERMINAL));

  // Holding at the terminal value keeps the count from wrapping inside a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_deframer.sv
// serial_deframer: start/data/[parity]/stop deframer with a one-word output holding register.
// Optional even parity bit enabled by macro SERIAL_DEFRAMER_PARITY_EN. Revision: 1.0
`default_nettype none

module serial_deframer
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             bit_en,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_tc;
  logic             shift_en;
  logic             par_cap;
  logic             complete;

  serial_bit_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (WIDTH - 1)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    shift_en  = 1'b0;
    par_cap   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (bit_en && (d == START_BIT)) begin
          cnt_load  = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_en) begin
          shift_en = 1'b1;
          if (cnt_tc) begin
`ifdef SERIAL_DEFRAMER_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
`ifdef SERIAL_DEFRAMER_PARITY_EN
      PARITY: begin
        if (bit_en) begin
          par_cap   = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_en) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // New bits enter at the top so the first data bit ends up in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {d, shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (complete) begin
        frame_err <= ~d;
        if (!q_valid || q_ready) begin
          q       <= shreg;
          q_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_cap) begin
        par_bit <= d;
      end
      if (complete) begin
        parity_err <= (^shreg) ^ par_bit;
      end
    end
  end
`else
  assign parity_err = 1'b0;
  logic unused_par;
  assign unused_par = par_cap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_deframer.sv
// tb_serial_deframer: directed table-driven bench for serial_deframer (WIDTH=8).
// Revision: 1.0
`default_nettype none

module tb_serial_deframer;
  import serial_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             d = 1'b1;
  logic             bit_en = 1'b0;
  logic             q_ready = 1'b0;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;

  int total = 0;
  int bad = 0;
  logic mon = 1'b0;
  int pulses = 0;

  serial_deframer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .bit_en     (bit_en),
    .q          (q),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!mon) pulses <= 0;
    else if (q_valid) pulses <= pulses + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_q;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the strobing posedge
  // (plus gap cycles, during which d is driven to the wrong value).
  task automatic send_bit(input logic b, input int gap);
    d = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    for (int i = 0; i < gap; i++) begin
      d = ~b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop, input int gap);
    send_bit(START_BIT, gap);
    for (int i = 0; i < WIDTH; i++) send_bit(data[i], gap);
`ifdef SERIAL_DEFRAMER_PARITY_EN
    send_bit(par, gap);
`else
    if (par === 1'bx) $display("parity input unknown");
`endif
    send_bit(stop, 0);
    d = IDLE_LEVEL;
  endtask

  initial begin
    tbl[0] = '{8'h9A, 1'b1, 8'h9A, 1'b0};
    tbl[1] = '{8'h9A, 1'b0, 8'h9A, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    tbl[4] = '{8'h81, 1'b1, 8'h81, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_q", 32'(q), 32'h0);
    check("reset_q_valid", 32'(q_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    q_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_bit(IDLE_LEVEL, 0);
      send_frame(tbl[k].data, ^tbl[k].data, tbl[k].stop, 0);
      check($sformatf("tbl%0d_q", k), 32'(q), 32'(tbl[k].exp_q));
      check($sformatf("tbl%0d_valid", k), 32'(q_valid), 32'h1);
      check($sformatf("tbl%0d_ferr", k), 32'(frame_err), 32'(tbl[k].exp_ferr));
      check($sformatf("tbl%0d_overrun", k), 32'(overrun), 32'h0);
      check($sformatf("tbl%0d_perr", k), 32'(parity_err), 32'h0);
      @(negedge clk);
      check($sformatf("tbl%0d_valid_clear", k), 32'(q_valid), 32'h0);
      check($sformatf("tbl%0d_q_hold", k), 32'(q), 32'(tbl[k].exp_q));
    end

    // Back-pressure: second frame dropped, first word held.
    q_ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1, 0);
    check("ovr_first_q", 32'(q), 32'h11);
    check("ovr_first_valid", 32'(q_valid), 32'h1);
    check("ovr_first_flag", 32'(overrun), 32'h0);
    send_frame(8'h22, ^8'h22, 1'b1, 0);
    check("ovr_second_q", 32'(q), 32'h11);
    check("ovr_second_valid", 32'(q_valid), 32'h1);
    check("ovr_second_flag", 32'(overrun), 32'h1);
    q_ready = 1'b1;
    @(negedge clk);
    check("ovr_drain_valid", 32'(q_valid), 32'h0);
    check("ovr_drain_q", 32'(q), 32'h11);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // Reset in the middle of a frame, then one clean frame.
    mon = 1'b1;
    send_bit(START_BIT, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(q_valid), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    check("midrst_q", 32'(q), 32'h0);
    rst = 1'b0;
    send_frame(8'h3C, ^8'h3C, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("midrst_pulses", 32'(pulses), 32'h1);
    check("midrst_q_after", 32'(q), 32'h3C);
    mon = 1'b0;

    // Sparse strobes with d toggling between them.
    send_frame(8'hA5, ^8'hA5, 1'b1, 3);
    check("sparse_q", 32'(q), 32'hA5);
    check("sparse_valid", 32'(q_valid), 32'h1);
    check("sparse_ferr", 32'(frame_err), 32'h0);
    @(negedge clk);

`ifdef SERIAL_DEFRAMER_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, 0);
    check("par_bad_q", 32'(q), 32'h07);
    check("par_bad_err", 32'(parity_err), 32'h1);
    @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("par_good_q", 32'(q), 32'h07);
    check("par_good_err", 32'(parity_err), 32'h0);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
